// File: rtl/if_bpu.sv
// if_bpu: IF-stage next-PC predictor.
// Decodes JAL/JALR/BRANCH from the fetched word and predicts direction and
// target in the same cycle. Conditional branches consult a table of 2-bit
// saturating counters trained from EX; returns come from a small circular
// return address stack.
module if_bpu #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int RAS_DEPTH   = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           instr_valid_i,
  input  logic [XLEN-1:0]                pc_i,
  input  logic [31:0]                    instr_i,
  input  logic                           stall_i,
  input  logic                           flush_i,
  input  logic                           upd_valid_i,
  input  logic [XLEN-1:0]                upd_pc_i,
  input  logic                           upd_taken_i,
  output logic                           pred_cf_o,
  output logic                           pred_taken_o,
  output logic [XLEN-1:0]                pred_target_o,
  output logic [$clog2(RAS_DEPTH):0]     ras_cnt_o
);

  localparam int IDX = $clog2(BHT_ENTRIES);
  localparam int PW  = $clog2(RAS_DEPTH);
  localparam logic [PW:0] CNT_MAX = (PW+1)'(RAS_DEPTH);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // State
  logic [1:0]      bht [BHT_ENTRIES];
  logic [XLEN-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]   ptr;      // next free slot; top entry sits at ptr-1
  logic [PW:0]     cnt;

  // Decode
  logic [6:0]      opcode;
  logic [4:0]      rd, rs1;
  logic            is_jal, is_jalr, is_br;
  logic            rd_link, rs1_link;
  logic            is_call, is_ret;
  logic [XLEN-1:0] imm_j, imm_b;
  logic [XLEN-1:0] pc_plus4;
  logic [PW-1:0]   top_idx;
  logic [IDX-1:0]  lk_idx, up_idx;
  logic [1:0]      lk_ctr;
  logic            fire;
  logic            unused_upd_bits;

  assign opcode   = instr_i[6:0];
  assign rd       = instr_i[11:7];
  assign rs1      = instr_i[19:15];
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);
  assign is_br    = (opcode == OP_BRANCH);
  assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
  assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);

  // A JALR with the same link register as rd and rs1 is a plain call, not a
  // return; distinct link registers on both sides is a coroutine swap.
  assign is_ret  = is_jalr && rs1_link && !(rd_link && (rd == rs1));
  assign is_call = (is_jal || is_jalr) && rd_link;

  assign imm_j = {{(XLEN-21){instr_i[31]}}, instr_i[31], instr_i[19:12],
                  instr_i[20], instr_i[30:21], 1'b0};
  assign imm_b = {{(XLEN-13){instr_i[31]}}, instr_i[31], instr_i[7],
                  instr_i[30:25], instr_i[11:8], 1'b0};

  assign pc_plus4 = pc_i + XLEN'(4);
  assign top_idx  = ptr - PW'(1);
  assign lk_idx   = pc_i[IDX+1:2];
  assign up_idx   = upd_pc_i[IDX+1:2];
  assign lk_ctr   = bht[lk_idx];
  assign fire     = instr_valid_i && !stall_i && !flush_i;
  assign ras_cnt_o = cnt;

  // Only the index bits of the update PC address the table.
  assign unused_upd_bits = ^{upd_pc_i[XLEN-1:IDX+2], upd_pc_i[1:0]};

  // Same-cycle prediction; lookups see pre-update table contents.
  always_comb begin
    pred_cf_o     = 1'b0;
    pred_taken_o  = 1'b0;
    pred_target_o = pc_plus4;
    if (instr_valid_i) begin
      if (is_jal) begin
        pred_cf_o     = 1'b1;
        pred_taken_o  = 1'b1;
        pred_target_o = pc_i + imm_j;
      end else if (is_br) begin
        pred_cf_o = 1'b1;
        if (lk_ctr[1]) begin
          pred_taken_o  = 1'b1;
          pred_target_o = pc_i + imm_b;
        end
      end else if (is_jalr) begin
        pred_cf_o = 1'b1;
        // Non-return JALRs and returns with an empty stack fall through;
        // EX resolves them.
        if (is_ret && (cnt != '0)) begin
          pred_taken_o  = 1'b1;
          pred_target_o = ras[top_idx];
        end
      end
    end
  end

  // Return address stack: circular, oldest entry overwritten when full.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr <= '0;
      cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
    end else if (flush_i) begin
      ptr <= '0;
      cnt <= '0;
    end else if (fire) begin
      if (is_call && is_ret && (cnt != '0)) begin
        ras[top_idx] <= pc_plus4;
      end else if (is_call) begin
        ras[ptr] <= pc_plus4;
        ptr      <= ptr + PW'(1);
        if (cnt != CNT_MAX) cnt <= cnt + (PW+1)'(1);
      end else if (is_ret && (cnt != '0)) begin
        ptr <= top_idx;
        cnt <= cnt - (PW+1)'(1);
      end
    end
  end

  // Branch history table: 2-bit saturating counters trained from EX.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (upd_valid_i) begin
      if (upd_taken_i) begin
        if (bht[up_idx] != 2'b11) bht[up_idx] <= bht[up_idx] + 2'b01;
      end else begin
        if (bht[up_idx] != 2'b00) bht[up_idx] <= bht[up_idx] - 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_if_bpu.sv
// Directed bench for if_bpu: a table of single-cycle vectors followed by
// hand-written multi-cycle RAS/reset/update sequences.
module tb_if_bpu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv, st, fl, uv, ut;
  logic [31:0] pc, ins, upc;
  logic        cf, tk;
  logic [31:0] tgt;
  logic [2:0]  cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  if_bpu #(.XLEN(32), .BHT_ENTRIES(64), .RAS_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .instr_valid_i(iv), .pc_i(pc), .instr_i(ins),
    .stall_i(st), .flush_i(fl), .upd_valid_i(uv), .upd_pc_i(upc),
    .upd_taken_i(ut), .pred_cf_o(cf), .pred_taken_o(tk),
    .pred_target_o(tgt), .ras_cnt_o(cnt)
  );

  typedef struct {
    string       name;
    logic        iv;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic        e_cf;
    logic        e_tk;
    logic [31:0] e_tgt;
    logic [2:0]  e_cnt;   // count seen before this vector's edge
  } vec_t;

  vec_t tv[$];

  function automatic logic [31:0] enc_j(input logic [4:0] r, input int imm);
    logic [31:0] m;
    m = imm;
    return {m[20], m[10:1], m[11], m[19:12], r, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_b(input int imm);
    logic [31:0] m;
    m = imm;
    return {m[12], m[10:5], 5'd0, 5'd0, 3'b000, m[4:1], m[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jr(input logic [4:0] r, input logic [4:0] s);
    return {12'd0, s, 3'b000, r, 7'b1100111};
  endfunction

  function automatic vec_t mk(input string n, input logic v, input logic [31:0] p,
                              input logic [31:0] i, input logic u, input logic [31:0] up,
                              input logic ud, input logic ecf, input logic etk,
                              input logic [31:0] et, input logic [2:0] ec);
    vec_t t;
    t.name = n; t.iv = v; t.pc = p; t.ins = i; t.uv = u; t.upc = up; t.ut = ud;
    t.e_cf = ecf; t.e_tk = etk; t.e_tgt = et; t.e_cnt = ec;
    return t;
  endfunction

  task automatic chk(input string n, input logic ecf, input logic etk,
                     input logic [31:0] et, input logic [2:0] ec);
    n_chk++;
    if ({cf, tk, tgt, cnt} !== {ecf, etk, et, ec}) begin
      n_fail++;
      $display("FAIL %s: got cf=%0b tk=%0b tgt=%h cnt=%0d, want cf=%0b tk=%0b tgt=%h cnt=%0d",
               n, cf, tk, tgt, cnt, ecf, etk, et, ec);
    end
  endtask

  task automatic chk_cnt(input string n, input logic [2:0] ec);
    n_chk++;
    if (cnt !== ec) begin
      n_fail++;
      $display("FAIL %s: got cnt=%0d, want cnt=%0d", n, cnt, ec);
    end
  endtask

  // Drive one fetch on the falling edge, leaving update/stall/flush idle.
  task automatic fetch(input logic [31:0] p, input logic [31:0] i,
                       input logic s, input logic f);
    @(negedge clk);
    iv = 1'b1; pc = p; ins = i; st = s; fl = f; uv = 1'b0; upc = '0; ut = 1'b0;
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    iv = 1'b0; pc = 32'h0; ins = 32'h13; st = 1'b0; fl = 1'b0; uv = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; iv = 1'b0; st = 1'b0; fl = 1'b0; uv = 1'b0;
    pc = '0; ins = 32'h13; upc = '0; ut = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0] br, ret, call;

  initial begin
    iv = 1'b0; st = 1'b0; fl = 1'b0; uv = 1'b0; ut = 1'b0;
    pc = '0; ins = NOP; upc = '0;
    br   = enc_b(-16);
    ret  = enc_jr(5'd0, 5'd1);
    call = enc_j(5'd1, 32'h100);

    // ---- table: BHT training, basic JAL/JALR, RAS overflow/underflow ----
    tv.push_back(mk("inval",      0, 32'h100, br,  0, 0, 0, 0, 0, 32'h104, 0));
    tv.push_back(mk("br_rst_sameupd", 1, 32'h100, br, 1, 32'h100, 1, 1, 0, 32'h104, 0));
    tv.push_back(mk("br_c2",      1, 32'h100, br,  1, 32'h100, 1, 1, 1, 32'h0F0, 0));
    tv.push_back(mk("br_c3",      1, 32'h100, br,  0, 0, 0, 1, 1, 32'h0F0, 0));
    tv.push_back(mk("br_nt1",     1, 32'h100, br,  1, 32'h100, 0, 1, 1, 32'h0F0, 0));
    tv.push_back(mk("br_nt2",     1, 32'h100, br,  1, 32'h100, 0, 1, 1, 32'h0F0, 0));
    tv.push_back(mk("br_nt3",     1, 32'h100, br,  1, 32'h100, 0, 1, 0, 32'h104, 0));
    tv.push_back(mk("br_nt4",     1, 32'h100, br,  1, 32'h100, 0, 1, 0, 32'h104, 0));
    tv.push_back(mk("br_nt5_sat", 1, 32'h100, br,  1, 32'h100, 0, 1, 0, 32'h104, 0));
    tv.push_back(mk("br_c0_tk",   1, 32'h100, br,  1, 32'h100, 1, 1, 0, 32'h104, 0));
    tv.push_back(mk("br_c1",      1, 32'h100, br,  0, 0, 0, 1, 0, 32'h104, 0));
    tv.push_back(mk("br_idx1",    1, 32'h104, br,  0, 0, 0, 1, 0, 32'h108, 0));
    tv.push_back(mk("other_op",   1, 32'h400, NOP, 0, 0, 0, 0, 0, 32'h404, 0));
    tv.push_back(mk("jal_wrap",   1, 32'hFFFF_FFF0, enc_j(5'd0, 32'h20), 0, 0, 0, 1, 1, 32'h10, 0));
    tv.push_back(mk("jal_neg",    1, 32'h1000, enc_j(5'd0, -32'h40), 0, 0, 0, 1, 1, 32'hFC0, 0));
    tv.push_back(mk("ret_empty",  1, 32'h300, ret, 0, 0, 0, 1, 0, 32'h304, 0));
    tv.push_back(mk("jal_call",   1, 32'h200, enc_j(5'd1, 32'h20), 0, 0, 0, 1, 1, 32'h220, 0));
    tv.push_back(mk("jalr_plain", 1, 32'h280, enc_jr(5'd0, 5'd6), 0, 0, 0, 1, 0, 32'h284, 1));
    tv.push_back(mk("ret_pop",    1, 32'h300, ret, 0, 0, 0, 1, 1, 32'h204, 1));
    tv.push_back(mk("after_pop",  0, 32'h300, ret, 0, 0, 0, 0, 0, 32'h304, 0));
    for (int k = 0; k < 5; k++)
      tv.push_back(mk($sformatf("push%0d", k), 1, 32'(k*16), call, 0, 0, 0,
                      1, 1, 32'(k*16 + 32'h100), 3'(k)));
    tv.push_back(mk("ret_44",     1, 32'h800, ret, 0, 0, 0, 1, 1, 32'h44, 4));
    tv.push_back(mk("ret_34",     1, 32'h800, ret, 0, 0, 0, 1, 1, 32'h34, 3));
    tv.push_back(mk("ret_24",     1, 32'h800, ret, 0, 0, 0, 1, 1, 32'h24, 2));
    tv.push_back(mk("ret_14",     1, 32'h800, ret, 0, 0, 0, 1, 1, 32'h14, 1));
    tv.push_back(mk("ret_5th",    1, 32'h800, ret, 0, 0, 0, 1, 0, 32'h804, 0));
    tv.push_back(mk("after_ret5", 0, 32'h800, NOP, 0, 0, 0, 0, 0, 32'h804, 0));

    do_reset();
    for (int k = 0; k < tv.size(); k++) begin
      @(negedge clk);
      iv = tv[k].iv; pc = tv[k].pc; ins = tv[k].ins; st = 1'b0; fl = 1'b0;
      uv = tv[k].uv; upc = tv[k].upc; ut = tv[k].ut;
      #1;
      chk(tv[k].name, tv[k].e_cf, tv[k].e_tk, tv[k].e_tgt, tv[k].e_cnt);
    end

    // ---- stall suppresses push ----
    do_reset();
    fetch(32'h200, call, 1'b1, 1'b0);
    idle();
    chk_cnt("stall_nopush", 0);

    // ---- flush after two pushes clears count ----
    fetch(32'h10, call, 1'b0, 1'b0);
    fetch(32'h20, call, 1'b0, 1'b0);
    idle();
    chk_cnt("two_push", 2);
    fetch(32'h30, call, 1'b0, 1'b1);
    idle();
    chk_cnt("flush_clr", 0);
    fetch(32'h40, ret, 1'b0, 1'b0);
    chk("ret_after_flush", 1, 0, 32'h44, 0);

    // ---- asynchronous reset between edges ----
    fetch(32'h50, call, 1'b0, 1'b0);
    idle();
    chk_cnt("pre_async", 1);
    #1 rst = 1'b1;
    #1;
    chk_cnt("async_rst", 0);
    rst = 1'b0;

    // ---- coroutine swap replaces top ----
    do_reset();
    fetch(32'h0FC, call, 1'b0, 1'b0);
    fetch(32'h4FC, call, 1'b0, 1'b0);
    fetch(32'h600, enc_jr(5'd1, 5'd5), 1'b0, 1'b0);
    chk("corout", 1, 1, 32'h500, 2);
    fetch(32'h700, ret, 1'b0, 1'b0);
    chk("corout_top", 1, 1, 32'h604, 2);
    fetch(32'h704, ret, 1'b0, 1'b0);
    chk("corout_below", 1, 1, 32'h100, 1);

    // ---- coroutine with empty stack acts as push ----
    do_reset();
    fetch(32'h900, enc_jr(5'd5, 5'd1), 1'b0, 1'b0);
    chk("corout_empty", 1, 0, 32'h904, 0);
    fetch(32'hA00, ret, 1'b0, 1'b0);
    chk("corout_empty_pushed", 1, 1, 32'h904, 1);

    // ---- same-cycle update/lookup, counter at 1 ----
    do_reset();
    @(negedge clk);
    iv = 1'b1; pc = 32'h140; ins = br; st = 1'b0; fl = 1'b0;
    uv = 1'b1; upc = 32'h140; ut = 1'b1;
    #1;
    chk("same_cyc_pre", 1, 0, 32'h144, 0);
    @(negedge clk);
    uv = 1'b0;
    #1;
    chk("same_cyc_next", 1, 1, 32'h130, 0);

    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_bpu.md
Name: if_bpu

Overview:
- IF-stage next-PC predictor; successor to the single-instruction IF mini-decoder.
- Decodes the fetched instruction for JAL/JALR/BRANCH and predicts taken/target in the same cycle.
- Conditional branches use a parametrised table of 2-bit saturating counters (BHT), trained from EX.
- Returns are predicted from a parametrised return address stack (RAS).

Parameters:
XLEN, 32, datapath/PC width
BHT_ENTRIES, 64, number of BHT counters, power of two >=2; IDX = log2(BHT_ENTRIES)
RAS_DEPTH, 4, RAS entries, power of two >=2

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
instr_valid_i  in  1  instr_i/pc_i valid this cycle
pc_i  in  XLEN  PC of instr_i
instr_i  in  32  fetched instruction
stall_i  in  1  IF held; no RAS update
flush_i  in  1  pipeline redirect from EX; clears RAS
upd_valid_i  in  1  EX branch-resolution strobe
upd_pc_i  in  XLEN  PC of resolved conditional branch
upd_taken_i  in  1  resolved direction
pred_cf_o  out  1  instr is JAL/JALR/BRANCH (gated by instr_valid_i)
pred_taken_o  out  1  redirect fetch to pred_target_o
pred_target_o  out  XLEN  next fetch PC
ras_cnt_o  out  log2(RAS_DEPTH)+1  valid RAS entries

Behaviour:
- Prediction outputs are combinational from instr_i, pc_i, BHT and RAS state. There is no added latency. Only BHT, RAS and ras_cnt_o are registered.
- Reset (async, rst_i=1): all BHT counters = 2'b01 (weakly not-taken); RAS top pointer = 0; ras_cnt_o = 0; RAS data = 0.
- instr_valid_i=0: pred_cf_o=0, pred_taken_o=0, pred_target_o=pc_i+4.
- Decode uses opcode[6:0]: JAL 1101111, JALR 1100111, BRANCH 1100011. Immediates are J-type and B-type, sign-extended to XLEN. link(r) = (r==1 || r==5).
- JAL: taken=1, target=pc_i+immJ.
- BRANCH: index = pc_i[IDX+1:2]; taken = counter[1]; target = taken ? pc_i+immB : pc_i+4.
- JALR classification:
  - ret = link(rs1) && !(link(rd) && rd==rs1).
  - call = link(rd).
  - ret with ras_cnt>0: taken=1, target = RAS top.
  - Any other JALR, including ret with an empty RAS: taken=0, target=pc_i+4. EX resolves these.
- Other opcodes: pred_cf_o=0, taken=0, target=pc_i+4.
- RAS update occurs only when fire = instr_valid_i & ~stall_i & ~flush_i.
  - Call only (JAL or JALR with link rd, not ret): push pc_i+4. If full, overwrite the oldest entry circularly; count saturates at RAS_DEPTH.
  - Ret only: pop. If empty, no change; count never goes below 0.
  - Call and ret together (rd≠rs1, both link): replace top with pc_i+4; count unchanged. If count==0, this is a push.
- flush_i=1: on the next edge ras_cnt=0 and pointer=0. Flush has priority over fire.
- BHT update on upd_valid_i, independent of stall/flush:
  - index = upd_pc_i[IDX+1:2].
  - Taken increments the counter, saturating at 3; not-taken decrements, saturating at 0.
- A same-cycle lookup and update of the same index: the lookup returns the pre-update value. There is no bypass.
- All PC arithmetic is modulo 2^XLEN; wrap-around is allowed.
- Reset asserted mid-operation: state returns to reset values immediately, without waiting for a clock edge.

Test Plan:
- After reset: BRANCH at pc 0x100 with imm -16 -> pred_cf_o=1, pred_taken_o=0, target 0x104. Two updates taken at 0x100 -> same lookup gives taken=1, target 0xF0. Four not-taken updates -> counter 0; a fifth not-taken stays at 0.
- JAL x1,+0x20 at 0x200 -> taken, target 0x220, ras_cnt 1. Then JALR x0,0(x1) at 0x300 -> taken, target 0x204, ras_cnt 0.
- RAS_DEPTH=4: push five calls from PCs 0x0,0x10,0x20,0x30,0x40 -> ras_cnt 4. Five returns -> targets 0x44,0x34,0x24,0x14, then the fifth return is not taken with target pc+4, and ras_cnt stays 0.
- Call with stall_i=1 -> no push. Call with flush_i=1 after two pushes -> ras_cnt 0 on the next edge. rst_i pulsed between edges -> ras_cnt_o=0 immediately.
- Coroutine JALR x1,0(x5) with RAS top 0x500, cnt 2, at pc 0x600 -> taken, target 0x500; after the edge top=0x604, cnt 2.
- upd_valid_i and a lookup to the same index in the same cycle, counter at 1, upd_taken_i=1 -> that cycle predicts not-taken; the next cycle predicts taken.
